// File: rtl/bcd_time_if.sv
// Control and display bundle between the BCD time core and its host.
// The master drives the set/mode inputs; the slave returns time and frame.
interface bcd_time_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int NLED = 4 * NUM_DIGITS;

    logic                fast;
    logic                mode_12h;
    logic                inc_min;
    logic                inc_hour;
    logic                tick;
    logic [23:0]         time_bcd;
    logic                pm;
    logic [24*NLED-1:0]  led_rgb_data;
    logic                frame_update;

    modport master (
        output fast, mode_12h, inc_min, inc_hour,
        input  tick, time_bcd, pm, led_rgb_data, frame_update
    );

    modport slave (
        input  fast, mode_12h, inc_min, inc_hour,
        output tick, time_bcd, pm, led_rgb_data, frame_update
    );
endinterface

// File: rtl/bcd_time_core.sv
// Synchronous BCD time-of-day engine with 12/24h display and LED frame.
// One tick enable drives the carry chain; the frame lags time by one cycle.
module bcd_time_core #(
    parameter int          CLK_HZ     = 12000000,
    parameter int          FAST_DIV   = 2000,
    parameter int          NUM_DIGITS = 4,
    parameter logic [23:0] ON_RGB     = 24'h10_10_10,
    parameter logic [23:0] FAST_RGB   = 24'h00_10_00
) (
    input  logic       hwclk,
    input  logic       reset,
    bcd_time_if.slave  bus
);
    localparam int NLED   = 4 * NUM_DIGITS;
    localparam int PW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int FAST_P = (CLK_HZ / FAST_DIV < 1) ? 1 : CLK_HZ / FAST_DIV;
    localparam logic [PW-1:0] LIM_NORM = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] LIM_FAST = PW'(FAST_P - 1);

    logic [PW-1:0] cnt_q, cnt_d, lim;
    logic          tick_c;

    logic [3:0] h1_q, h0_q, m1_q, m0_q, s1_q, s0_q;
    logic [3:0] h1_d, h0_d, m1_d, m0_d, s1_d, s0_d;
    logic       pm_q, pm_d;

    logic [4:0] hbin;
    logic [3:0] h12, dh1, dh0;
    logic [NLED-1:0]    disp;
    logic [23:0]        colour;
    logic [24*NLED-1:0] frame_d, led_q;
    logic               fu_q;

    function automatic logic [7:0] inc60(input logic [3:0] d1,
                                         input logic [3:0] d0);
        if (d0 != 4'd9) return {d1, d0 + 4'd1};
        if (d1 != 4'd5) return {d1 + 4'd1, 4'd0};
        return 8'h00;
    endfunction

    function automatic logic [7:0] inc24(input logic [3:0] d1,
                                         input logic [3:0] d0);
        if (d1 == 4'd2 && d0 == 4'd3) return 8'h00;
        if (d0 == 4'd9) return {d1 + 4'd1, 4'd0};
        return {d1, d0 + 4'd1};
    endfunction

    // >= rather than == so a shorter period wraps at once
    assign lim    = bus.fast ? LIM_FAST : LIM_NORM;
    assign tick_c = (cnt_q >= lim);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (bus.inc_min || tick_c) cnt_d = '0;
    end

    always_comb begin
        h1_d = h1_q;
        h0_d = h0_q;
        m1_d = m1_q;
        m0_d = m0_q;
        s1_d = s1_q;
        s0_d = s0_q;
        if (bus.inc_min || bus.inc_hour) begin
            if (bus.inc_min) begin
                {m1_d, m0_d} = inc60(m1_q, m0_q);
                s1_d = 4'd0;
                s0_d = 4'd0;
            end
            if (bus.inc_hour) {h1_d, h0_d} = inc24(h1_q, h0_q);
        end else if (tick_c) begin
            {s1_d, s0_d} = inc60(s1_q, s0_q);
            if (s1_q == 4'd5 && s0_q == 4'd9) begin
                {m1_d, m0_d} = inc60(m1_q, m0_q);
                if (m1_q == 4'd5 && m0_q == 4'd9)
                    {h1_d, h0_d} = inc24(h1_q, h0_q);
            end
        end
        pm_d = (h1_d == 4'd2) || (h1_d == 4'd1 && h0_d >= 4'd2);
    end

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            h1_q  <= '0;
            h0_q  <= '0;
            m1_q  <= '0;
            m0_q  <= '0;
            s1_q  <= '0;
            s0_q  <= '0;
            pm_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            h1_q  <= h1_d;
            h0_q  <= h0_d;
            m1_q  <= m1_d;
            m0_q  <= m0_d;
            s1_q  <= s1_d;
            s0_q  <= s0_d;
            pm_q  <= pm_d;
        end
    end

    // h12 is only meaningful for hours 13..23; mod-16 math is exact there
    always_comb begin
        hbin = {1'b0, h1_q} * 5'd10 + {1'b0, h0_q};
        h12  = hbin[3:0] - 4'd12;
        dh1  = h1_q;
        dh0  = h0_q;
        if (bus.mode_12h) begin
            if (hbin == 5'd0) begin
                dh1 = 4'd1;
                dh0 = 4'd2;
            end else if (hbin > 5'd12) begin
                if (h12 >= 4'd10) begin
                    dh1 = 4'd1;
                    dh0 = h12 - 4'd10;
                end else begin
                    dh1 = 4'd0;
                    dh0 = h12;
                end
            end
        end
    end

    generate
        if (NUM_DIGITS == 6) begin : g_six
            assign disp = {dh1, dh0, m1_q, m0_q, s1_q, s0_q};
        end else begin : g_four
            logic unused_hr;
            assign unused_hr = ^{dh1, dh0};
            assign disp = {m1_q, m0_q, s1_q, s0_q};
        end
    endgenerate

    always_comb begin
        colour  = bus.fast ? FAST_RGB : ON_RGB;
        frame_d = '0;
        for (int i = 0; i < NLED; i++)
            if (disp[i]) frame_d[24*i +: 24] = colour;
    end

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            led_q <= '0;
            fu_q  <= 1'b0;
        end else begin
            led_q <= frame_d;
            fu_q  <= (frame_d != led_q);
        end
    end

    assign bus.tick         = tick_c & ~reset;
    assign bus.time_bcd     = {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q};
    assign bus.pm           = pm_q;
    assign bus.led_rgb_data = led_q;
    assign bus.frame_update = fu_q;
endmodule

// File: doc/bcd_time_core.md
Name: bcd_time_core

Overview:
Parametrised BCD time-of-day engine for the binary LED clock. It replaces the rippled per-digit counters with one fully synchronous core on hwclk, driven by a single-cycle tick enable. It adds 12/24-hour display, minute/hour set inputs, a fast-run mode and selectable 4- or 6-digit display. It emits the packed RGB frame consumed by the ws2812 driver.

Parameters:
CLK_HZ, 12000000, hwclk frequency; normal tick period in cycles
FAST_DIV, 2000, divisor applied to CLK_HZ in fast mode (fast period = CLK_HZ/FAST_DIV cycles, min 1)
NUM_DIGITS, 4, displayed digits: 4 = mm:ss, 6 = hh:mm:ss (other values illegal)
ON_RGB, 24'h10_10_10, colour of lit LEDs in normal mode
FAST_RGB, 24'h00_10_00, colour of lit LEDs in fast mode

Ports:
hwclk  in  1  system clock
reset  in  1  asynchronous, active-high reset
fast  in  1  level; select fast tick period
mode_12h  in  1  level; 1 = 12-hour display, 0 = 24-hour
inc_min  in  1  single-cycle pulse; advance minutes (pre-synchronised)
inc_hour  in  1  single-cycle pulse; advance hours (pre-synchronised)
tick  out  1  one-cycle pulse per counted second
time_bcd  out  24  internal 24h time {h1,h0,m1,m0,s1,s0}, 4 bits each
pm  out  1  1 when internal hour >= 12
led_rgb_data  out  24*4*NUM_DIGITS  packed frame; LED i at bits [24*i +: 24]
frame_update  out  1  one-cycle pulse when led_rgb_data has just changed

Behaviour:
- Reset (async assert, sync release): prescaler, time_bcd, tick, pm, led_rgb_data, frame_update all 0.
- Prescaler: counts 0..P-1, P = CLK_HZ (fast=0) or CLK_HZ/FAST_DIV (fast=1). At count >= P-1: count <= 0 and tick = 1 for that one cycle. The >= compare makes a switch to a shorter P wrap on the next cycle, never overrunning.
- Counting on tick: s0 0..9, s1 0..5, m0 0..9, m1 0..5, h0/h1 00..23. Carries propagate in the same cycle, so 23:59:59 -> 00:00:00 on one tick. Digits never hold non-BCD values.
- inc_min: m <= (m+1) mod 60, no carry into hours, s <= 00, prescaler <= 0.
- inc_hour: h <= (h+1) mod 24; minutes and seconds untouched.
- Priority: inc_min/inc_hour take precedence. A tick in the same cycle is discarded (the tick output still pulses). inc_min and inc_hour together apply both.
- pm = (h >= 12), registered with time_bcd.
- Display digits, combinational from time_bcd:
  - 24h: as stored.
  - 12h: hour 0 -> 12; 13..23 -> h-12; 1..12 unchanged.
  - Minutes/seconds are identical in both modes.
- Display vector D: {m1,m0,s1,s0} (NUM_DIGITS=4) or {H1,H0,m1,m0,s1,s0} (NUM_DIGITS=6), s0 in the LSBs.
- Frame: one cycle after any change of D or colour, led_rgb_data[24*i +: 24] <= D[i] ? colour : 0, where colour = fast ? FAST_RGB : ON_RGB. frame_update pulses in that same cycle.
- Latency: tick cycle N -> time_bcd updated at N+1 -> led_rgb_data/frame_update at N+2.
- No frame_update when D and colour are unchanged (e.g. a discarded tick with no set effect cannot occur; an idle mode_12h toggle at hour 05 gives no update).
- Reset mid-count: immediate return to 00:00:00 with frame all-zero. No tick is emitted on reset release.

Test Plan:
- CLK_HZ=10, reset, 10 cycles -> one tick at cycle 10 (count 9), time_bcd=24'h000001, frame_update 2 cycles later, LED0 = 24'h101010, all other LEDs 0.
- Preload via inc_hour x23 and inc_min x59, then 59 ticks -> 23:59:59; next tick -> time_bcd=0, pm 1->0, frame all-zero.
- NUM_DIGITS=6, mode_12h=1, hour 00 -> display H1:H0=1:2. Hour 13 -> 0:1 with pm=1. Toggle mode_12h at hour 13 -> frame changes, frame_update pulses once.
- fast=1 (CLK_HZ=10, FAST_DIV=5) while prescaler=7 -> wrap next cycle, then tick every 2 cycles. Lit LEDs become 24'h001000 with a frame_update.
- inc_min asserted in the same cycle as a tick at 00:00:30 -> 00:01:00, prescaler restarts, next tick 10 cycles later -> 00:01:01.
- Assert reset mid-count at 00:12:34 -> all outputs 0 asynchronously. After release, first tick at cycle 10 -> 00:00:01.
